// File: rtl/tblink_rpc_pkt_tx.sv
// tblink_rpc_pkt_tx: serialises one RPC message into a byte stream.
// The packet layout is DST, SRC, SIZE, CMD, ID, then the parameter words.
// Parameter words go out word 0 first, each word least-significant byte first.
// The message is captured on acceptance, so the inputs may change once the
// packet has started.
module tblink_rpc_pkt_tx #(
  parameter int ADDR        = 0,
  parameter int PARAM_WORDS = 4
) (
  input  logic                     uclock,
  input  logic                     reset,
  input  logic [7:0]               msg_dst,
  input  logic [7:0]               msg_cmd,
  input  logic [7:0]               msg_id,
  input  logic [3:0]               msg_len,
  input  logic [32*PARAM_WORDS-1:0] msg_params,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  output logic [7:0]               neto_dat,
  output logic                     neto_valid,
  input  logic                     neto_ready,
  output logic                     busy,
  output logic                     len_err
);

  localparam int         PW_BITS  = 32 * PARAM_WORDS;
  localparam logic [3:0] MAX_LEN  = 4'(PARAM_WORDS);
  localparam logic [7:0] SRC_ADDR = 8'(ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_DST, S_SRC, S_SIZE, S_CMD, S_ID, S_PARAM
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         dst_q, cmd_q, id_q;
  logic [3:0]         len_q;
  logic [PW_BITS-1:0] params_q;
  logic [5:0]         cnt_q;
  logic               len_err_q;

  logic               accept;
  logic               step;
  logic               last_byte;
  logic [7:0]         size_byte;
  logic [7:0]         param_byte;

  // Longer requests are truncated to the words the port can carry.
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  // Ready is gated by reset so it reads 0 for the whole reset interval.
  assign msg_ready  = (state == S_IDLE) && reset;
  assign accept     = msg_valid && msg_ready;
  assign neto_valid = (state != S_IDLE);
  assign busy       = (state != S_IDLE);
  assign step       = neto_valid && neto_ready;
  assign len_err    = len_err_q;

  // SIZE counts CMD, ID and the parameter bytes.
  assign size_byte  = 8'd2 + {2'b00, len_q, 2'b00};
  assign param_byte = 8'(params_q >> {cnt_q, 3'b000});
  assign last_byte  = (cnt_q == ({len_q, 2'b00} - 6'd1));

  // State register.
  always_ff @(posedge uclock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: each non-idle state advances only on a byte handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_DST;
      S_DST:   if (step)   state_nxt = S_SRC;
      S_SRC:   if (step)   state_nxt = S_SIZE;
      S_SIZE:  if (step)   state_nxt = S_CMD;
      S_CMD:   if (step)   state_nxt = S_ID;
      S_ID:    if (step)   state_nxt = (len_q == 4'd0) ? S_IDLE : S_PARAM;
      S_PARAM: if (step && last_byte) state_nxt = S_IDLE;
      default:             state_nxt = S_IDLE;
    endcase
  end

  // Output byte mux: the byte holds until its handshake because it depends only on state.
  always_comb begin
    neto_dat = 8'h00;
    case (state)
      S_DST:   neto_dat = dst_q;
      S_SRC:   neto_dat = SRC_ADDR;
      S_SIZE:  neto_dat = size_byte;
      S_CMD:   neto_dat = cmd_q;
      S_ID:    neto_dat = id_q;
      S_PARAM: neto_dat = param_byte;
      default: neto_dat = 8'h00;
    endcase
  end

  // Message capture, parameter byte counter and sticky length-error flag.
  always_ff @(posedge uclock or negedge reset) begin
    if (!reset) begin
      dst_q     <= 8'h00;
      cmd_q     <= 8'h00;
      id_q      <= 8'h00;
      len_q     <= 4'd0;
      params_q  <= '0;
      cnt_q     <= 6'd0;
      len_err_q <= 1'b0;
    end else begin
      if (accept) begin
        dst_q    <= msg_dst;
        cmd_q    <= msg_cmd;
        id_q     <= msg_id;
        len_q    <= clamp_len(msg_len);
        params_q <= msg_params;
        cnt_q    <= 6'd0;
        if (msg_len > MAX_LEN) len_err_q <= 1'b1;
      end else if (state == S_PARAM && step) begin
        cnt_q <= last_byte ? 6'd0 : cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_tblink_rpc_pkt_tx.sv
// Directed bench for tblink_rpc_pkt_tx with ADDR=1, PARAM_WORDS=4.
module tb_tblink_rpc_pkt_tx;

  logic         uclock;
  logic         reset;
  logic [7:0]   msg_dst, msg_cmd, msg_id;
  logic [3:0]   msg_len;
  logic [127:0] msg_params;
  logic         msg_valid;
  logic         msg_ready;
  logic [7:0]   neto_dat;
  logic         neto_valid;
  logic         neto_ready;
  logic         busy;
  logic         len_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  tblink_rpc_pkt_tx #(.ADDR(1), .PARAM_WORDS(4)) dut (
    .uclock     (uclock),
    .reset      (reset),
    .msg_dst    (msg_dst),
    .msg_cmd    (msg_cmd),
    .msg_id     (msg_id),
    .msg_len    (msg_len),
    .msg_params (msg_params),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .neto_dat   (neto_dat),
    .neto_valid (neto_valid),
    .neto_ready (neto_ready),
    .busy       (busy),
    .len_err    (len_err)
  );

  initial uclock = 1'b0;
  always #5 uclock = ~uclock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge uclock);
    #1;
  endtask

  // Present a message and wait for its acceptance edge (callers are at posedge+1).
  task automatic send(input logic [7:0] d, input logic [7:0] c, input logic [7:0] i,
                      input logic [3:0] l, input logic [127:0] p);
    msg_dst = d; msg_cmd = c; msg_id = i; msg_len = l; msg_params = p;
    msg_valid = 1'b1;
    chk("ready_before_accept", msg_ready, 1'b1);
    tick();
    msg_valid = 1'b0;
    msg_dst = 8'hEE; msg_cmd = 8'hEE; msg_id = 8'hEE; msg_len = 4'hE; msg_params = '1;
    chk("valid_1cyc_after_accept", neto_valid, 1'b1);
    chk("busy_after_accept", busy, 1'b1);
  endtask

  // Reference packet built from the packet format with ADDR=1, PARAM_WORDS=4.
  task automatic build_exp(input logic [7:0] d, input logic [7:0] c, input logic [7:0] i,
                           input logic [3:0] l, input logic [127:0] p);
    int eff;
    eff = (l > 4) ? 4 : int'(l);
    exp_q.delete();
    exp_q.push_back(d);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(2 + 4 * eff));
    exp_q.push_back(c);
    exp_q.push_back(i);
    for (int w = 0; w < eff; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(p[w*32 + b*8 +: 8]);
  endtask

  // Collect n bytes, optionally stalling randomly, checking hold behaviour.
  task automatic recv(input int n, input bit stall);
    int         cyc;
    bit         hold;
    logic [7:0] hold_d;
    logic       r;
    rx.delete();
    cyc  = 0;
    hold = 1'b0;
    hold_d = 8'h00;
    while (rx.size() < n && cyc < 400) begin
      r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      neto_ready = r;
      if (hold) begin
        chk("stall_valid_held", neto_valid, 1'b1);
        chk("stall_data_held", neto_dat, hold_d);
      end
      hold = 1'b0;
      if (neto_valid) begin
        if (r) rx.push_back(neto_dat);
        else begin
          hold   = 1'b1;
          hold_d = neto_dat;
        end
      end
      tick();
      cyc++;
    end
    chk("byte_count", rx.size(), n);
  endtask

  task automatic cmp_rx(input string tag);
    for (int k = 0; k < exp_q.size() && k < rx.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), rx[k], exp_q[k]);
  endtask

  initial begin
    reset = 1'b0;
    msg_dst = 8'h00; msg_cmd = 8'h00; msg_id = 8'h00; msg_len = 4'd0;
    msg_params = '0; msg_valid = 1'b0; neto_ready = 1'b0;
    #1;
    chk("rst_msg_ready", msg_ready, 1'b0);
    chk("rst_neto_valid", neto_valid, 1'b0);
    chk("rst_neto_dat", neto_dat, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("ready_after_reset", msg_ready, 1'b1);
    tick();

    // neto_ready with nothing to send is ignored
    neto_ready = 1'b1;
    tick();
    tick();
    chk("idle_ready_ignored_valid", neto_valid, 1'b0);
    chk("idle_ready_ignored_busy", busy, 1'b0);

    // len=1 packet, no stalls
    send(8'h02, 8'h10, 8'h05, 4'd1, {96'h0, 32'h11223344});
    recv(9, 1'b0);
    exp_q = {8'h02, 8'h01, 8'h06, 8'h10, 8'h05, 8'h44, 8'h33, 8'h22, 8'h11};
    cmp_rx("len1");
    chk("len1_busy_low", busy, 1'b0);
    chk("len1_valid_low", neto_valid, 1'b0);
    chk("len1_ready_back", msg_ready, 1'b1);

    // len=0 packet: header only
    send(8'h33, 8'hA0, 8'h7F, 4'd0, 128'h0);
    recv(5, 1'b0);
    exp_q = {8'h33, 8'h01, 8'h02, 8'hA0, 8'h7F};
    cmp_rx("len0");
    chk("len0_idle_after_id", busy, 1'b0);
    chk("len0_no_param_byte", neto_valid, 1'b0);

    // len=4 packet with random downstream stalls
    send(8'h5A, 8'h21, 8'h09, 4'd4,
         128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    recv(21, 1'b1);
    build_exp(8'h5A, 8'h21, 8'h09, 4'd4, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    cmp_rx("stall4");
    chk("stall4_busy_low", busy, 1'b0);
    neto_ready = 1'b1;

    // over-long length is clamped and flagged
    chk("len_err_before", len_err, 1'b0);
    send(8'h44, 8'h30, 8'h31, 4'd7, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("len_err_set", len_err, 1'b1);
    recv(21, 1'b0);
    chk("len7_size_byte", rx.size() > 2 ? rx[2] : 8'hXX, 8'h12);
    build_exp(8'h44, 8'h30, 8'h31, 4'd7, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    cmp_rx("len7");
    tick();
    tick();
    chk("len_err_sticky", len_err, 1'b1);

    // reset in the middle of a packet
    send(8'h66, 8'h77, 8'h88, 4'd2, {64'h0, 64'hAAAAAAAA_BBBBBBBB});
    recv(3, 1'b0);
    chk("mid_busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_msg_ready", msg_ready, 1'b0);
    chk("mid_rst_neto_valid", neto_valid, 1'b0);
    chk("mid_rst_neto_dat", neto_dat, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_len_err", len_err, 1'b0);
    tick();
    tick();
    chk("mid_rst_still_quiet", neto_valid, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_ready_after_reset", msg_ready, 1'b1);
    chk("mid_no_old_bytes", neto_valid, 1'b0);
    tick();
    send(8'h12, 8'h34, 8'h56, 4'd1, {96'h0, 32'h9ABCDEF0});
    recv(9, 1'b0);
    exp_q = {8'h12, 8'h01, 8'h06, 8'h34, 8'h56, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
    cmp_rx("post_rst");

    // back-to-back messages with msg_valid held
    send(8'hB1, 8'hC1, 8'hD1, 4'd1, {96'h0, 32'h01020304});
    msg_dst = 8'hB2; msg_cmd = 8'hC2; msg_id = 8'hD2; msg_len = 4'd2;
    msg_params = {64'h0, 64'h55667788_11223344};
    msg_valid = 1'b1;
    recv(9, 1'b0);
    exp_q = {8'hB1, 8'h01, 8'h06, 8'hC1, 8'hD1, 8'h04, 8'h03, 8'h02, 8'h01};
    cmp_rx("b2b_first");
    chk("b2b_bubble_ready", msg_ready, 1'b1);
    chk("b2b_bubble_valid", neto_valid, 1'b0);
    tick();
    msg_valid = 1'b0;
    chk("b2b_second_started", neto_valid, 1'b1);
    chk("b2b_second_ready_low", msg_ready, 1'b0);
    recv(13, 1'b0);
    exp_q = {8'hB2, 8'h01, 8'h0A, 8'hC2, 8'hD2,
             8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    cmp_rx("b2b_second");
    chk("b2b_end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tblink_rpc_pkt_tx.md
TBLINK_RPC_PKT_TX -- requirements
Module: tblink_rpc_pkt_tx

Interface
REQ-001 SHALL have parameter ADDR, default 0, meaning the 8-bit source network address inserted in every packet.
REQ-002 SHALL have parameter PARAM_WORDS, default 4, range 1..15, meaning the maximum 32-bit parameter words per message.
REQ-003 SHALL have port uclock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port msg_dst  input  8  meaning the destination network address.
REQ-006 SHALL have port msg_cmd  input  8  meaning the RPC command code.
REQ-007 SHALL have port msg_id  input  8  meaning the RPC call/transaction id.
REQ-008 SHALL have port msg_len  input  4  meaning the number of valid parameter words.
REQ-009 SHALL have port msg_params  input  32*PARAM_WORDS  meaning the parameter words; word k occupies bits [32k+31:32k].
REQ-010 SHALL have port msg_valid  input  1  meaning the message request is valid.
REQ-011 SHALL have port msg_ready  output  1  meaning the block accepts a message.
REQ-012 SHALL have port neto_dat  output  8  meaning the network byte out.
REQ-013 SHALL have port neto_valid  output  1  meaning neto_dat is valid.
REQ-014 SHALL have port neto_ready  input  1  meaning the downstream consumer accepts the byte.
REQ-015 SHALL have port busy  output  1  meaning a packet is in progress.
REQ-016 SHALL have port len_err  output  1  meaning sticky flag: a message with msg_len > PARAM_WORDS was accepted.

Function
REQ-017 SHALL emit the packet byte order DST, SRC(=ADDR), SIZE, CMD, ID, then parameter bytes.
REQ-018 SHALL emit parameter bytes word 0 first, each word least-significant byte first.
REQ-019 SHALL compute SIZE = 2 + 4*L as an 8-bit value, where L is the effective length; SIZE counts the bytes after the SIZE byte.
REQ-020 SHALL clamp the effective length to PARAM_WORDS when msg_len > PARAM_WORDS, and set len_err on the same acceptance.
REQ-021 SHALL implement FSM states IDLE, DST, SRC, SIZE, CMD, ID, PARAM.
REQ-022 SHALL drive msg_ready=1 only in IDLE; acceptance occurs when msg_valid && msg_ready at a rising edge.
REQ-023 SHALL register dst, cmd, id, the effective length and all params on acceptance; inputs are don't-care afterwards.
REQ-024 SHALL go IDLE->DST on acceptance and assert neto_valid on the next cycle; latency from acceptance to the first byte presented is 1 cycle.
REQ-025 SHALL advance exactly one byte per cycle in which neto_valid && neto_ready; otherwise neto_dat and neto_valid SHALL hold.
REQ-026 SHALL go ID->IDLE when L=0, else ID->PARAM.
REQ-027 SHALL step a 6-bit byte counter through 0..4L-1 in PARAM and return to IDLE after byte 4L-1 is accepted.
REQ-028 SHALL NOT deassert neto_valid before the handshake completes once it is asserted.
REQ-029 SHALL accept the next message in the IDLE cycle immediately after the final byte is accepted, giving a 1-cycle bubble between back-to-back packets.
REQ-030 SHALL drive busy=1 in every state except IDLE.
REQ-031 SHALL accept neto_ready asserted while neto_valid=0 and ignore it.
REQ-032 SHALL keep the maximum packet at 5 + 4*PARAM_WORDS bytes, with no counter wrap within a packet.

Reset
REQ-033 SHALL, while reset=0, force the state to IDLE, msg_ready=0, neto_valid=0, neto_dat=0, busy=0, len_err=0 and clear the byte counter and all capture registers.
REQ-034 SHALL discard any packet in progress when reset is asserted mid-packet, emitting no further bytes of it.
REQ-035 SHALL drive msg_ready=1 in the first clock cycle after reset deassertion.

Verification
REQ-036 Bench SHALL cover ADDR=1, dst=0x02, cmd=0x10, id=0x05, len=1, param0=0x11223344, neto_ready=1 -> bytes 02 01 06 10 05 44 33 22 11, and busy falls after byte 9.
REQ-037 Bench SHALL cover len=0, cmd=0xA0, id=0x7F -> bytes dst 01 02 A0 7F, and ID->IDLE with no PARAM bytes.
REQ-038 Bench SHALL cover random neto_ready stalls on a len=4 message -> 21 bytes, each value stable while stalled, no byte dropped or duplicated.
REQ-039 Bench SHALL cover msg_len=7 with PARAM_WORDS=4 -> SIZE=0x12, 16 parameter bytes, and len_err=1 until reset.
REQ-040 Bench SHALL cover reset pulse after the 3rd byte -> all outputs 0 during reset, a fresh message afterwards starts at DST, and no old bytes appear.
REQ-041 Bench SHALL cover two messages held valid back-to-back -> second accepted 1 cycle after the last byte of the first, and both packets correct.
